// File: rtl/alu_issue_decoder.sv
// Registered RV32I ALU decoder with valid/ready issue and multi-cycle M sequencing.
// Define ALU_ISSUE_RV32M_EN to compile in RV32M decode and the WAIT/counter path.
module alu_issue_decoder #(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              out_illegal,
    output logic              out_multicycle
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] C_ADD   = 5'd0;
    localparam logic [4:0] C_SUB   = 5'd1;
    localparam logic [4:0] C_AND   = 5'd2;
    localparam logic [4:0] C_OR    = 5'd3;
    localparam logic [4:0] C_XOR   = 5'd4;
    localparam logic [4:0] C_SLT   = 5'd5;
    localparam logic [4:0] C_SLTU  = 5'd6;
    localparam logic [4:0] C_SLL   = 5'd7;
    localparam logic [4:0] C_SRL   = 5'd8;
    localparam logic [4:0] C_SRA   = 5'd9;
    localparam logic [4:0] C_LUI   = 5'd10;
    localparam logic [4:0] C_AUIPC = 5'd11;

    generate
        if (CTRL_W < 5 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_param
            $error("alu_issue_decoder: need CTRL_W>=5, MUL_LAT>=1, DIV_LAT>=1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic              ill_q;
    logic              accept;

    logic [4:0] dec_code;
    logic       dec_ill;
    logic       is_op, is_imm, is_add, is_branch, is_lui, is_auipc;

`ifdef ALU_ISSUE_RV32M_EN
    localparam logic [6:0] F7_M = 7'b0000001;
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, dec_cnt;
    logic             dec_mc, mc_q;
`endif

    function automatic logic [4:0] base_code(input logic [2:0] f3);
        logic [4:0] c;
        case (f3)
            3'b000:  c = C_ADD;
            3'b001:  c = C_SLL;
            3'b010:  c = C_SLT;
            3'b011:  c = C_SLTU;
            3'b100:  c = C_XOR;
            3'b101:  c = C_SRL;
            3'b110:  c = C_OR;
            default: c = C_AND;
        endcase
        return c;
    endfunction

    assign is_op     = (opcode == OPC_OP);
    assign is_imm    = (opcode == OPC_IMM);
    assign is_add    = (opcode == OPC_LOAD) || (opcode == OPC_STORE) ||
                       (opcode == OPC_JALR) || (opcode == OPC_JAL);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);

    always_comb begin
        dec_code = C_ADD;
        dec_ill  = 1'b0;
`ifdef ALU_ISSUE_RV32M_EN
        dec_mc   = 1'b0;
        dec_cnt  = '0;
`endif
        unique case (1'b1)
            is_op: begin
                if (funct7 == F7_BASE) begin
                    dec_code = base_code(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_code = C_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_code = C_SRA;
`ifdef ALU_ISSUE_RV32M_EN
                end else if (funct7 == F7_M) begin
                    dec_code = 5'd12 + {2'b00, funct3};
                    dec_mc   = 1'b1;
                    dec_cnt  = funct3[2] ? DIV_CNT : MUL_CNT;
`endif
                end else begin
                    dec_ill = 1'b1;
                end
            end
            is_imm: begin
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    dec_ill = 1'b1;
                end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                    dec_code = C_SRA;
                end else if (funct3 == 3'b101 && funct7 != F7_BASE) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_code = base_code(funct3);
                end
            end
            is_add:    dec_code = C_ADD;
            is_branch: dec_code = C_SUB;
            is_lui:    dec_code = C_LUI;
            is_auipc:  dec_code = C_AUIPC;
            default:   dec_ill  = 1'b1;
        endcase
        if (dec_ill) dec_code = C_ADD;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_e go;
        go = S_VALID;
`ifdef ALU_ISSUE_RV32M_EN
        // LAT==1 M ops skip WAIT so they still land one edge after accept
        if (dec_mc && dec_cnt != '0) go = S_WAIT;
`endif
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) state_d = go;
`ifdef ALU_ISSUE_RV32M_EN
                S_WAIT: if (cnt_q <= CNT_W'(1)) state_d = S_VALID;
`endif
                S_VALID: begin
                    if (out_ready) state_d = accept ? go : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = !rst && !flush &&
                    (state_q == S_IDLE ||
                     (state_q == S_VALID && out_ready));
        accept    = in_valid && in_ready;
        out_valid = (state_q == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            ill_q  <= 1'b0;
        end else if (accept) begin
            ctrl_q <= CTRL_W'(dec_code);
            ill_q  <= dec_ill;
        end
    end

`ifdef ALU_ISSUE_RV32M_EN
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = dec_cnt;
        end else if (state_q == S_WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            mc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) mc_q <= dec_mc;
        end
    end

    assign out_multicycle = mc_q;
`else
    assign out_multicycle = 1'b0;
`endif

    assign alu_control = ctrl_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: random and directed issue
// against a table-level decode model with per-op latency.
module tb_alu_issue_decoder;

    localparam int CTRL_W  = 5;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;
`ifdef ALU_ISSUE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready;
    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic              out_valid, out_ready;
    logic [CTRL_W-1:0] alu_control;
    logic              out_illegal, out_multicycle;

    alu_issue_decoder #(
        .CTRL_W (CTRL_W),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_control   (alu_control),
        .out_illegal   (out_illegal),
        .out_multicycle(out_multicycle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        bit ill;
        bit mc;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name,
                                  input longint act, input longint exp);
        ntests++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // Reference decode: RISC-V tables, result code plus latency in edges
    function automatic exp_t model(input logic [6:0] op,
                                   input logic [2:0] f3,
                                   input logic [6:0] f7);
        int   rtab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        exp_t e;
        e.code = 0; e.ill = 0; e.mc = 0; e.due = 1;
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00) e.code = rtab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.code = 1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.code = 9;
                else if (f7 == 7'h01 && M_EN) begin
                    e.code = 12 + int'(f3);
                    e.mc   = 1;
                    e.due  = (f3 < 3'd4) ? MUL_LAT : DIV_LAT;
                end else e.ill = 1;
            end
            7'b0010011: begin
                if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1;
                else if (f3 == 3'd5 && f7 == 7'h20) e.code = 9;
                else if (f3 == 3'd5 && f7 != 7'h00) e.ill = 1;
                else e.code = rtab[f3];
            end
            7'b0000011, 7'b0100011,
            7'b1100111, 7'b1101111: e.code = 0;
            7'b1100011: e.code = 1;
            7'b0110111: e.code = 10;
            7'b0010111: e.code = 11;
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    // Issue side: record each accepted op with the cycle its result is due
    always @(posedge clk) begin
        if (in_valid && in_ready) begin
            exp_t e;
            e = model(opcode, funct3, funct7);
            e.due = cyc + e.due;
            sb.push_back(e);
        end
    end

    // Output side: handshake expectations, then pop on consumer take
    always @(negedge clk) begin
        if (cyc > 0) begin
            bit exp_v, exp_r;
            exp_v = (sb.size() > 0) && (cyc >= sb[0].due);
            exp_r = !rst && !flush && (sb.size() == 0 || (exp_v && out_ready));
            check(in_ready == exp_r, "in_ready", in_ready, exp_r);
            check(out_valid == exp_v, "out_valid", out_valid, exp_v);
            if (out_valid && exp_v && out_ready) begin
                check(int'(alu_control) == sb[0].code, "alu_control",
                      alu_control, sb[0].code);
                check(out_illegal == sb[0].ill, "out_illegal",
                      out_illegal, sb[0].ill);
                check(out_multicycle == sb[0].mc, "out_multicycle",
                      out_multicycle, sb[0].mc);
                void'(sb.pop_front());
            end
            if (rst || flush) sb.delete();
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, output int waits);
        opcode = op; funct3 = f3; funct7 = f7; in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            nxt();
            @(negedge clk);
            waits++;
        end
        check(waits < 100, "send_timeout", waits, 100);
        nxt();
        in_valid = 1'b0;
    endtask

    function automatic logic [6:0] rand_opc();
        case ($urandom_range(0, 12))
            0, 1, 2: return 7'b0110011;
            3, 4:    return 7'b0010011;
            5:       return 7'b0000011;
            6:       return 7'b0100011;
            7:       return 7'b1100111;
            8:       return 7'b1101111;
            9:       return 7'b1100011;
            10:      return 7'b0110111;
            11:      return 7'b0010111;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [6:0] rand_f7();
        case ($urandom_range(0, 3))
            0:       return 7'h00;
            1:       return 7'h20;
            2:       return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        opcode = 0; funct3 = 0; funct7 = 0;
        repeat (2) nxt();
        @(negedge clk);
        check(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        nxt();
        rst = 0;
        @(negedge clk);
        check(alu_control == '0, "reset_ctrl", alu_control, 0);
        check(out_illegal == 1'b0, "reset_ill", out_illegal, 0);
        check(out_multicycle == 1'b0, "reset_mc", out_multicycle, 0);
        check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        nxt();

        out_ready = 1;
        send(7'b0110011, 3'd0, 7'h20, w);
        @(negedge clk);
        check(out_valid == 1'b1, "sub_valid", out_valid, 1);
        check(alu_control == 5'd1, "sub_code", alu_control, 1);
        nxt();
        for (int i = 0; i < 6; i++) begin
            send(7'b0010011, 3'd5, 7'h20, w);
            check(w == 0, "srai_bubble", w, 0);
        end
        send(7'b0010011, 3'd1, 7'h20, w);
        send(7'b1110011, 3'd0, 7'h00, w);
        send(7'b1100011, 3'd0, 7'h00, w);
        send(7'b0110111, 3'd0, 7'h00, w);
        repeat (2) nxt();

        send(7'b0110011, 3'd0, 7'h01, w);
        @(negedge clk);
        check(in_ready == !M_EN, "mul_c1_ready", in_ready, !M_EN);
        check(out_valid == !M_EN, "mul_c1_valid", out_valid, !M_EN);
        nxt();
        @(negedge clk);
        check(out_valid == M_EN, "mul_c2_valid", out_valid, M_EN);
        check(int'(alu_control) == (M_EN ? 12 : 0), "mul_code",
              alu_control, M_EN ? 12 : 0);
        check(out_multicycle == M_EN, "mul_mc", out_multicycle, M_EN);
        check(out_illegal == !M_EN, "mul_ill", out_illegal, !M_EN);
        repeat (2) nxt();

        send(7'b0110011, 3'd5, 7'h01, w);
        repeat (9) nxt();
        flush = 1;
        nxt();
        flush = 0;
        @(negedge clk);
        check(in_ready == 1'b1, "flush_c11_ready", in_ready, 1);
        check(out_valid == 1'b0, "flush_c11_valid", out_valid, 0);
        repeat (2) nxt();

        send(7'b0110011, 3'd5, 7'h01, w);
        repeat (9) nxt();
        rst = 1;
        nxt();
        rst = 0;
        @(negedge clk);
        check(in_ready == 1'b1, "rst_c11_ready", in_ready, 1);
        check(out_valid == 1'b0, "rst_c11_valid", out_valid, 0);
        check(alu_control == '0, "rst_c11_ctrl", alu_control, 0);
        check(out_illegal == 1'b0, "rst_c11_ill", out_illegal, 0);
        check(out_multicycle == 1'b0, "rst_c11_mc", out_multicycle, 0);
        nxt();

        out_ready = 0;
        send(7'b0110011, 3'd4, 7'h00, w);
        opcode = 7'b0110011; funct3 = 3'd7; funct7 = 7'h00; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(alu_control == 5'd4, "hold_code", alu_control, 4);
            check(out_valid == 1'b1, "hold_valid", out_valid, 1);
            check(in_ready == 1'b0, "hold_ready", in_ready, 0);
            nxt();
        end
        out_ready = 1;
        nxt();
        in_valid = 0;
        @(negedge clk);
        check(alu_control == 5'd2, "and_code", alu_control, 2);
        check(out_valid == 1'b1, "and_valid", out_valid, 1);
        nxt();

        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            opcode    = rand_opc();
            funct3    = 3'($urandom);
            funct7    = rand_f7();
            nxt();
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            nxt();
            w++;
        end
        check(sb.size() == 0, "drain", sb.size(), 0);
        nxt();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
